fetch_decode_register: RTL and testbench
========================================

# fetch_decode_register

Pipeline register between the fetch stage and the decode stage. Captures the fetched instruction and PC, and holds them while the decode hazard stall is asserted. Squashes wrong-path instructions on a flush. Presents the decode-stage operand/destination fields that feed hazard detection, and signals the execute stage to take a bubble while decode is stalled.

## Interface
Parameters:
- WORD_WIDTH, 32, instruction and PC width
- REGISTER_INDEX_WIDTH, 5, register index width
- NOP_INSTRUCTION, 32'h00000033, canonical NOP (add x0,x0,x0)
- STALL_TIMEOUT, 64, consecutive stalled cycles that trip the watchdog (≥2, <256)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- fetch_valid  in  1  fetch presents a valid instruction this cycle
- fetch_instruction  in  WORD_WIDTH  fetched instruction
- fetch_pc  in  WORD_WIDTH  PC of fetched instruction
- stall  in  1  hazard stall for the instruction currently in decode
- flush  in  1  taken branch/jump resolved in execute; squash younger instructions
- fetch_ready  out  1  register will capture fetch input at next edge; = !stall_effective
- decode_valid  out  1  held instruction is real (not a bubble)
- decode_instruction  out  WORD_WIDTH  held instruction, NOP_INSTRUCTION when invalid
- decode_pc  out  WORD_WIDTH  held PC
- decode_op_code  out  7  decode_instruction[6:0]
- decode_idx_dst  out  REGISTER_INDEX_WIDTH  decode_instruction[11:7]
- decode_idx_src_1  out  REGISTER_INDEX_WIDTH  decode_instruction[19:15]
- decode_idx_src_2  out  REGISTER_INDEX_WIDTH  decode_instruction[24:20]
- execute_bubble  out  1  execute must load a NOP this cycle
- stall_cycles  out  8  consecutive stalled cycles of current instruction, saturating at 255
- stall_timeout  out  1  sticky watchdog flag

## Operation
- stall_effective = stall & decode_valid & (state == RUN). Stall against an invalid slot is ignored.
- States:
  - RUN: normal operation.
  - SQUASH: one cycle, entered after a flush, that discards the instruction fetched in the shadow of the branch.
- Edge priority: flush > SQUASH discard > stall_effective > load.
- flush (any state):
  - instruction <= NOP_INSTRUCTION, decode_valid <= 0, stall_cycles <= 0.
  - state <= SQUASH. Fetch input is dropped.
- SQUASH, no flush:
  - Fetch input is dropped. instruction stays NOP, decode_valid stays 0.
  - state <= RUN.
- RUN, stall_effective:
  - instruction, pc and valid are held.
  - stall_cycles <= min(stall_cycles+1, 255).
  - When stall_cycles+1 == STALL_TIMEOUT, stall_timeout <= 1.
- RUN, no stall, fetch_valid=1: capture instruction and pc, decode_valid <= 1, stall_cycles <= 0.
- RUN, no stall, fetch_valid=0: instruction <= NOP_INSTRUCTION, decode_valid <= 0, pc holds, stall_cycles <= 0.
- Field outputs are combinational slices of the held instruction. When invalid they decode as the NOP (opcode 0110011, all indices 0), so hazard detection never stalls on a bubble.
- execute_bubble = stall_effective | !decode_valid.
- stall_timeout is cleared only by reset. It is diagnostic and does not change flow.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - decode_instruction = NOP_INSTRUCTION, decode_pc = 0, decode_valid = 0
  - state = RUN, stall_cycles = 0, stall_timeout = 0
  - fetch_ready = 1, execute_bubble = 1
- Latency: a fetch input accepted at edge N appears on decode outputs after edge N (1 cycle).
- fetch_ready and execute_bubble are combinational from stall and registered state (stall is itself combinational from decode fields). There is no loop through fetch_ready.
- flush asserted at edge N: decode_valid = 0 after N and after N+1. The first post-flush fetch is captured at edge N+2.
- flush during SQUASH restarts SQUASH, so two consecutive flushes drop fetch inputs at both edges plus the next.
- stall and flush together: flush wins and the stalled instruction is discarded.
- Reset deassertion mid-stall: the register restarts in RUN with a bubble. No held state survives.
- Stall for K cycles, then release: the held instruction leaves at edge K+1. stall_cycles reads K before release and 0 after.

## Test plan
- Reset then stream fetch_valid=1 with PCs 0,4,8, no stall: decode_pc 0,4,8 on successive cycles; decode_valid=1 from cycle 1; execute_bubble=0.
- Load 0x002081B3 (add x3,x1,x2), stall=1 for 3 cycles: outputs hold; fields read opcode 0110011, src_1=1, src_2=2, dst=3; fetch_ready=0; execute_bubble=1; stall_cycles 1,2,3; next instruction captured on the release edge.
- flush at edge N with fetch_valid=1 every cycle: decode_valid=0 after N and N+1, instruction=32'h00000033; PC N+2 is captured.
- stall=1 while decode_valid=0: fetch_ready=1 and the next fetch is captured. Separately, stall and flush in the same cycle: flush wins, decode_valid=0.
- Hold stall for 70 cycles with STALL_TIMEOUT=64: stall_timeout rises on the 64th stalled edge and stays 1 after release, until rst_n is pulsed low.

Source files
------------

// File: rtl/fetch_decode_register.sv
// rtl/fetch_decode_register.sv - fetch/decode pipeline register with stall hold, flush squash and stall watchdog
module fetch_decode_register #(
    parameter int                 WORD_WIDTH           = 32,
    parameter int                 REGISTER_INDEX_WIDTH = 5,
    parameter logic [WORD_WIDTH-1:0] NOP_INSTRUCTION   = 32'h00000033,
    parameter int                 STALL_TIMEOUT        = 64
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            fetch_valid,
    input  logic [WORD_WIDTH-1:0]           fetch_instruction,
    input  logic [WORD_WIDTH-1:0]           fetch_pc,
    input  logic                            stall,
    input  logic                            flush,
    output logic                            fetch_ready,
    output logic                            decode_valid,
    output logic [WORD_WIDTH-1:0]           decode_instruction,
    output logic [WORD_WIDTH-1:0]           decode_pc,
    output logic [6:0]                      decode_op_code,
    output logic [REGISTER_INDEX_WIDTH-1:0] decode_idx_dst,
    output logic [REGISTER_INDEX_WIDTH-1:0] decode_idx_src_1,
    output logic [REGISTER_INDEX_WIDTH-1:0] decode_idx_src_2,
    output logic                            execute_bubble,
    output logic [7:0]                      stall_cycles,
    output logic                            stall_timeout
);

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    state_t     state;
    logic       stall_effective;
    logic [8:0] stall_next;

    // A stall against a bubble or during the squash cycle has nothing to hold.
    assign stall_effective = stall & decode_valid & (state == RUN);
    assign fetch_ready     = ~stall_effective;
    assign execute_bubble  = stall_effective | ~decode_valid;
    assign stall_next      = {1'b0, stall_cycles} + 9'd1;

    // Bubbles hold NOP_INSTRUCTION, so these slices read as the NOP's fields.
    assign decode_op_code   = decode_instruction[6:0];
    assign decode_idx_dst   = decode_instruction[7 +: REGISTER_INDEX_WIDTH];
    assign decode_idx_src_1 = decode_instruction[15 +: REGISTER_INDEX_WIDTH];
    assign decode_idx_src_2 = decode_instruction[20 +: REGISTER_INDEX_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= RUN;
            decode_instruction <= NOP_INSTRUCTION;
            decode_pc          <= '0;
            decode_valid       <= 1'b0;
            stall_cycles       <= 8'd0;
            stall_timeout      <= 1'b0;
        end else if (flush) begin
            state              <= SQUASH;
            decode_instruction <= NOP_INSTRUCTION;
            decode_valid       <= 1'b0;
            stall_cycles       <= 8'd0;
        end else if (state == SQUASH) begin
            // Drop the instruction fetched in the branch shadow.
            state              <= RUN;
            decode_instruction <= NOP_INSTRUCTION;
            decode_valid       <= 1'b0;
            stall_cycles       <= 8'd0;
        end else if (stall_effective) begin
            if (stall_next <= 9'd255) begin
                stall_cycles <= stall_next[7:0];
            end
            if (stall_next == 9'(STALL_TIMEOUT)) begin
                stall_timeout <= 1'b1;
            end
        end else if (fetch_valid) begin
            decode_instruction <= fetch_instruction;
            decode_pc          <= fetch_pc;
            decode_valid       <= 1'b1;
            stall_cycles       <= 8'd0;
        end else begin
            decode_instruction <= NOP_INSTRUCTION;
            decode_valid       <= 1'b0;
            stall_cycles       <= 8'd0;
        end
    end

endmodule

// File: tb/tb_fetch_decode_register.sv
// tb/tb_fetch_decode_register.sv - directed self-checking bench for fetch_decode_register
module tb_fetch_decode_register;

    localparam logic [31:0] NOP = 32'h00000033;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_valid;
    logic [31:0] fetch_instruction;
    logic [31:0] fetch_pc;
    logic        stall;
    logic        flush;
    logic        fetch_ready;
    logic        decode_valid;
    logic [31:0] decode_instruction;
    logic [31:0] decode_pc;
    logic [6:0]  decode_op_code;
    logic [4:0]  decode_idx_dst;
    logic [4:0]  decode_idx_src_1;
    logic [4:0]  decode_idx_src_2;
    logic        execute_bubble;
    logic [7:0]  stall_cycles;
    logic        stall_timeout;

    int checks = 0;
    int passes = 0;

    fetch_decode_register #(
        .WORD_WIDTH(32),
        .REGISTER_INDEX_WIDTH(5),
        .NOP_INSTRUCTION(32'h00000033),
        .STALL_TIMEOUT(64)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .fetch_valid(fetch_valid),
        .fetch_instruction(fetch_instruction),
        .fetch_pc(fetch_pc),
        .stall(stall),
        .flush(flush),
        .fetch_ready(fetch_ready),
        .decode_valid(decode_valid),
        .decode_instruction(decode_instruction),
        .decode_pc(decode_pc),
        .decode_op_code(decode_op_code),
        .decode_idx_dst(decode_idx_dst),
        .decode_idx_src_1(decode_idx_src_1),
        .decode_idx_src_2(decode_idx_src_2),
        .execute_bubble(execute_bubble),
        .stall_cycles(stall_cycles),
        .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] instr);
        fetch_valid       = 1'b1;
        fetch_pc          = pc;
        fetch_instruction = instr;
    endtask

    initial begin
        rst_n = 1'b0;
        fetch_valid = 1'b0;
        fetch_instruction = '0;
        fetch_pc = '0;
        stall = 1'b0;
        flush = 1'b0;
        #12;
        check("rst_instr", decode_instruction, NOP);
        check("rst_pc", decode_pc, 32'h0);
        check("rst_valid", {31'b0, decode_valid}, 32'h0);
        check("rst_cycles", {24'b0, stall_cycles}, 32'h0);
        check("rst_timeout", {31'b0, stall_timeout}, 32'h0);
        check("rst_ready", {31'b0, fetch_ready}, 32'h1);
        check("rst_bubble", {31'b0, execute_bubble}, 32'h1);
        check("rst_opcode", {25'b0, decode_op_code}, 32'h33);
        step();
        rst_n = 1'b1;

        // Streaming, no stall
        for (int i = 0; i < 3; i++) begin
            fetch(32'(i * 4), 32'h00100093 + 32'(i));
            step();
            check("stream_pc", decode_pc, 32'(i * 4));
            check("stream_valid", {31'b0, decode_valid}, 32'h1);
            check("stream_bubble", {31'b0, execute_bubble}, 32'h0);
        end

        // Stall holds add x3,x1,x2 for three edges
        fetch(32'h100, 32'h002081B3);
        step();
        fetch(32'h104, 32'h00000013);
        stall = 1'b1;
        #1;
        check("stall_ready", {31'b0, fetch_ready}, 32'h0);
        check("stall_bubble", {31'b0, execute_bubble}, 32'h1);
        check("stall_opcode", {25'b0, decode_op_code}, 32'h33);
        check("stall_src1", {27'b0, decode_idx_src_1}, 32'd1);
        check("stall_src2", {27'b0, decode_idx_src_2}, 32'd2);
        check("stall_dst", {27'b0, decode_idx_dst}, 32'd3);
        for (int k = 1; k <= 3; k++) begin
            step();
            check("stall_cycles", {24'b0, stall_cycles}, 32'(k));
            check("stall_hold_pc", decode_pc, 32'h100);
            check("stall_hold_instr", decode_instruction, 32'h002081B3);
        end
        stall = 1'b0;
        step();
        check("release_pc", decode_pc, 32'h104);
        check("release_cycles", {24'b0, stall_cycles}, 32'h0);

        // Flush with fetch_valid every cycle
        fetch(32'h200, 32'h00200113);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_n_valid", {31'b0, decode_valid}, 32'h0);
        check("flush_n_instr", decode_instruction, NOP);
        fetch(32'h204, 32'h00300193);
        step();
        check("flush_n1_valid", {31'b0, decode_valid}, 32'h0);
        check("flush_n1_instr", decode_instruction, NOP);
        fetch(32'h208, 32'h00400213);
        step();
        check("flush_n2_valid", {31'b0, decode_valid}, 32'h1);
        check("flush_n2_pc", decode_pc, 32'h208);

        // Stall against a bubble is ignored
        fetch_valid = 1'b0;
        step();
        check("idle_valid", {31'b0, decode_valid}, 32'h0);
        check("idle_pc_hold", decode_pc, 32'h208);
        fetch(32'h300, 32'h00500293);
        stall = 1'b1;
        #1;
        check("bubble_stall_ready", {31'b0, fetch_ready}, 32'h1);
        step();
        check("bubble_stall_capture", decode_pc, 32'h300);
        check("bubble_stall_valid", {31'b0, decode_valid}, 32'h1);

        // Stall and flush together
        flush = 1'b1;
        step();
        flush = 1'b0;
        stall = 1'b0;
        check("stall_flush_valid", {31'b0, decode_valid}, 32'h0);
        check("stall_flush_instr", decode_instruction, NOP);
        step();

        // Watchdog
        fetch(32'h400, 32'h002081B3);
        step();
        stall = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            step();
            if (k == 63) check("wd_before", {31'b0, stall_timeout}, 32'h0);
            if (k == 64) check("wd_trip", {31'b0, stall_timeout}, 32'h1);
        end
        check("wd_cycles70", {24'b0, stall_cycles}, 32'd70);
        stall = 1'b0;
        step();
        check("wd_sticky", {31'b0, stall_timeout}, 32'h1);
        check("wd_cycles_clr", {24'b0, stall_cycles}, 32'h0);

        // Reset mid-stall
        stall = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        check("rst2_timeout", {31'b0, stall_timeout}, 32'h0);
        check("rst2_valid", {31'b0, decode_valid}, 32'h0);
        check("rst2_bubble", {31'b0, execute_bubble}, 32'h1);
        step();
        rst_n = 1'b1;
        stall = 1'b0;
        fetch_valid = 1'b0;
        step();
        check("rst2_cycles", {24'b0, stall_cycles}, 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
